// File: rtl/trace_packet_decoder_pkg.sv
// rtl/trace_packet_decoder_pkg.sv - packet type codes and field positions shared with the packet assembler
package trace_packet_decoder_pkg;

  typedef enum logic [1:0] {
    PKT_ADDR  = 2'b00,
    PKT_READ  = 2'b01,
    PKT_WRITE = 2'b10,
    PKT_TIME  = 2'b11
  } pkt_type_e;

  localparam int TYPE_MSB    = 24;
  localparam int TYPE_LSB    = 23;
  localparam int PAYLOAD_MSB = 22;
  localparam int T5_MSB      = 22;
  localparam int T5_LSB      = 18;
  localparam int UBLB_MSB    = 17;
  localparam int UBLB_LSB    = 16;
  localparam int DATA_MSB    = 15;

  localparam int ADDR_W          = 23;
  localparam logic [7:0] IDX_MAX = 8'd255;

  function automatic pkt_type_e pkt_type(input logic [31:0] word);
    return pkt_type_e'(word[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/trace_time_acc.sv
// rtl/trace_time_acc.sv - 32-bit timestamp accumulator with sticky wrap detect
module trace_time_acc (
  input  logic        mclk,
  input  logic        reset,
  input  logic        add_en,
  input  logic [31:0] add_val,
  output logic [31:0] time_acc,
  output logic [31:0] time_sum,
  output logic        wrap_err
);

  logic [32:0] sum_full;

  // The sum is exposed so word events can carry the post-delta time in the same cycle
  assign sum_full = {1'b0, time_acc} + {1'b0, add_val};
  assign time_sum = sum_full[31:0];

  // Accumulate on request; a carry out of bit 31 latches the wrap flag until reset
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      time_acc <= '0;
      wrap_err <= 1'b0;
    end else if (add_en) begin
      time_acc <= sum_full[31:0];
      if (sum_full[32]) wrap_err <= 1'b1;
    end
  end

endmodule

// File: rtl/trace_packet_decoder.sv
// rtl/trace_packet_decoder.sv - decodes RAM trace packets into timestamped address/read/write events
module trace_packet_decoder
  import trace_packet_decoder_pkg::*;
(
  input  logic        mclk,
  input  logic        reset,
  input  logic [31:0] pkt_data,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_kind,
  output logic [22:0] ev_addr,
  output logic [15:0] ev_data,
  output logic [1:0]  ev_ublb,
  output logic [7:0]  ev_burst_idx,
  output logic [31:0] ev_time,
  output logic        err_no_addr,
  output logic        err_time_wrap
);

  pkt_type_e         kind;
  logic              accept;
  logic              is_word;
  logic              add_en;
  logic [31:0]       add_val;
  logic [31:0]       time_acc;
  logic [31:0]       time_sum;
  logic [ADDR_W-1:0] payload;
  logic [4:0]        t5;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        burst_idx;
  logic              addr_seen;
  logic              unused_reserved;

  // Reserved bits [31:25] carry no meaning for the decoder
  assign unused_reserved = ^pkt_data[31:25];

  assign kind    = pkt_type(pkt_data);
  assign payload = pkt_data[PAYLOAD_MSB:0];
  assign t5      = pkt_data[T5_MSB:T5_LSB];
  assign is_word = (kind == PKT_READ) || (kind == PKT_WRITE);

  // Single output register: a new word may enter whenever the held event leaves this cycle
  assign pkt_ready = !ev_valid || ev_ready;
  assign accept    = pkt_valid && pkt_ready;

  // Word packets add their 5-bit delta, timestamp packets their full payload
  assign add_en  = accept && (is_word || (kind == PKT_TIME));
  assign add_val = is_word ? {27'd0, t5} : {9'd0, payload};

  trace_time_acc u_time_acc (
    .mclk     (mclk),
    .reset    (reset),
    .add_en   (add_en),
    .add_val  (add_val),
    .time_acc (time_acc),
    .time_sum (time_sum),
    .wrap_err (err_time_wrap)
  );

  // Burst tracking: address packets open a burst, each word advances address and saturating index
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cur_addr    <= '0;
      burst_idx   <= '0;
      addr_seen   <= 1'b0;
      err_no_addr <= 1'b0;
    end else if (accept) begin
      if (kind == PKT_ADDR) begin
        cur_addr  <= payload;
        burst_idx <= '0;
        addr_seen <= 1'b1;
      end else if (is_word) begin
        cur_addr <= cur_addr + 1'b1;
        if (burst_idx != IDX_MAX) burst_idx <= burst_idx + 1'b1;
        if (!addr_seen) err_no_addr <= 1'b1;
      end
    end
  end

  // Event register: load on any event-producing word, otherwise drop once consumed
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      ev_valid     <= 1'b0;
      ev_kind      <= '0;
      ev_addr      <= '0;
      ev_data      <= '0;
      ev_ublb      <= '0;
      ev_burst_idx <= '0;
      ev_time      <= '0;
    end else if (accept && (kind == PKT_ADDR)) begin
      ev_valid     <= 1'b1;
      ev_kind      <= PKT_ADDR;
      ev_addr      <= payload;
      ev_data      <= '0;
      ev_ublb      <= '0;
      ev_burst_idx <= '0;
      ev_time      <= time_acc;
    end else if (accept && is_word) begin
      ev_valid     <= 1'b1;
      ev_kind      <= kind;
      ev_addr      <= cur_addr;
      ev_data      <= pkt_data[DATA_MSB:0];
      ev_ublb      <= pkt_data[UBLB_MSB:UBLB_LSB];
      ev_burst_idx <= burst_idx;
      ev_time      <= time_sum;
    end else if (ev_ready) begin
      ev_valid <= 1'b0;
    end
  end

endmodule

// File: doc/trace_packet_decoder.md
TRACE_PACKET_DECODER -- requirements
Module: trace_packet_decoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: mclk in 1, rising-edge clock; reset in 1, async active-high reset.
REQ-002 SHALL have port pkt_data, input, 32 bits: packet word; [24:23]=type, [22:0]=payload, [31:25] reserved and ignored.
REQ-003 SHALL have port pkt_valid, input, 1 bit: pkt_data valid this cycle.
REQ-004 SHALL have port pkt_ready, output, 1 bit: word accepted when pkt_valid && pkt_ready.
REQ-005 SHALL have port ev_valid, output, 1 bit: event register holds an event.
REQ-006 SHALL have port ev_ready, input, 1 bit: event consumed when ev_valid && ev_ready.
REQ-007 SHALL have port ev_kind, output, 2 bits: 00 address, 01 read, 10 write.
REQ-008 SHALL have port ev_addr, output, 23 bits: burst address (address event) or word address (read/write event).
REQ-009 SHALL have port ev_data, output, 16 bits: data word; 0 on address events.
REQ-010 SHALL have port ev_ublb, output, 2 bits: byte-lane bits; 0 on address events.
REQ-011 SHALL have port ev_burst_idx, output, 8 bits: word index within the current burst.
REQ-012 SHALL have port ev_time, output, 32 bits: absolute timestamp in mclk-sampled RAM cycles.
REQ-013 SHALL have port err_no_addr, output, 1 bit: sticky flag, word packet received before any address packet.
REQ-014 SHALL have port err_time_wrap, output, 1 bit: sticky flag, timestamp accumulator wrapped.

Function
REQ-015 Type codes SHALL be 00 address, 01 read word, 10 write word, 11 timestamp.
REQ-016 For word packets, payload[22:18] SHALL be time delta t5, [17:16] ublb, and [15:0] data.
REQ-017 A word SHALL be accepted only if pkt_valid && pkt_ready.
REQ-018 pkt_ready SHALL equal !ev_valid || ev_ready, giving a single-stage output register and full throughput.
REQ-019 An address packet SHALL set cur_addr=payload, clear burst_idx to 0, set addr_seen=1, emit kind 00 with ev_addr=payload and ev_time=time_acc, and leave time_acc unchanged.
REQ-020 A read or write packet SHALL compute t_new=time_acc+t5.
REQ-021 A read or write packet SHALL emit kind 01 (read) or 10 (write) with ev_addr=cur_addr, the data, ublb, ev_burst_idx=burst_idx and ev_time=t_new.
REQ-022 After a read or write packet, time_acc SHALL become t_new, cur_addr SHALL become cur_addr+1 mod 2^23, and burst_idx SHALL increment, saturating at 255.
REQ-023 A timestamp packet SHALL add payload (zero-extended) to time_acc and emit no event.
REQ-024 The latency from accepted word to ev_valid SHALL be 1 cycle.
REQ-025 ev_* SHALL be held stable while ev_valid && !ev_ready.
REQ-026 When ev_valid && ev_ready and no new event is accepted, ev_valid SHALL fall next cycle.
REQ-027 When an event is consumed and a new event-producing word is accepted in the same cycle, ev_valid SHALL stay 1 with the new contents.
REQ-028 A word packet received with addr_seen=0 SHALL set err_no_addr, still emit with ev_addr=cur_addr (0 after reset), and apply the normal increment.
REQ-029 Any 32-bit carry out of time_acc SHALL set err_time_wrap, and time_acc SHALL wrap modulo 2^32.
REQ-030 The sticky error flags SHALL clear only on reset.

Reset
REQ-031 Reset SHALL clear ev_valid, ev_kind, ev_addr, ev_data, ev_ublb, ev_burst_idx, ev_time, err_no_addr, err_time_wrap, time_acc, cur_addr, burst_idx and addr_seen to 0.
REQ-032 During reset, pkt_ready SHALL be 1.
REQ-033 Reset asserted mid-stream SHALL discard any pending event immediately.
REQ-034 The first word after reset deassertion SHALL be decoded against the cleared state.

Structure
REQ-035 Packet type codes and the field bit positions SHALL live in a shared include file, also used by the packet assembler.
REQ-036 The timestamp accumulator with wrap detect SHALL be a sub-module, trace_time_acc.
REQ-037 The decoder datapath SHALL otherwise be flat; no FIFO SHALL be inside this block.

Verification
REQ-038 Address 0x000100, then writes t5=3 data 0xBEEF ublb=00 and t5=2 data 0x1234 ublb=01 -> events addr 0x000100 time 0; write 0x000100 idx0 time 3; write 0x000101 idx1 time 5.
REQ-039 Timestamp packet 0x400000, then read t5=31 -> no event for the timestamp; read ev_time=0x40001F.
REQ-040 Address 0x7FFFFF, then two reads -> ev_addr 0x7FFFFF then 0x000000; idx 0 then 1.
REQ-041 Read with no prior address after reset -> err_no_addr=1, ev_addr=0, event still emitted; flag persists until reset.
REQ-042 Hold ev_ready=0 for 5 cycles while pkt_valid=1 -> pkt_ready=0 and ev_* stable; then ev_ready=1 -> one word per cycle and no loss or duplication.
REQ-043 300 reads after one address -> ev_burst_idx saturates at 255; assert reset mid-burst -> ev_valid=0 immediately and state cleared.
